// File: rtl/sobel_pkg.sv
// Shared defaults, FSM state encoding and Sobel kernel weights for the Sobel core.
package sobel_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 16;

    // Kernel weights: outer taps and the centre tap of each gradient column/row.
    localparam int K_SIDE = 1;
    localparam int K_MID  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage: combinational read, write on the clock edge.
// Read-before-write: a read and a write to the same address in one cycle return the old entry.
module sobel_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 5,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign rd_dat = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/sobel_filter_core.sv
// Sobel gradient-magnitude filter over a raster pixel stream; SOBEL_THRESHOLD_EN binarizes o_pixel.
// Latency: output k is valid two cycles after input k+IMAGE_WIDTH+1 is accepted; FLUSH drains the tail.
// Backpressure: none; gaps in i_valid stall the window, the consumer must take every o_valid.
module sobel_filter_core
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int THRESHOLD    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int N  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int GW = DATA_WIDTH + 3;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_OUT = ADDR_WIDTH'(IMAGE_WIDTH + 1);
    localparam logic [CW-1:0]         COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0]         ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [GW-1:0]         MAG_MAX   = {3'b000, {DATA_WIDTH{1'b1}}};

    if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3 || THRESHOLD < 0) begin : g_param_check
        $error("sobel_filter_core: image must be at least 3x3 and THRESHOLD non-negative");
    end

    state_e                state_q,    state_d;
    logic [CW-1:0]         in_col_q,   in_col_d;
    logic [ADDR_WIDTH-1:0] in_idx_q,   in_idx_d;
    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic [DATA_WIDTH-1:0] win_d [3][3];
    logic                  s1_vld_q,   s1_vld_d;
    logic [CW-1:0]         out_col_q,  out_col_d;
    logic [RW-1:0]         out_row_q,  out_row_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  o_valid_q,  o_valid_d;
    logic [DATA_WIDTH-1:0] o_pixel_q,  o_pixel_d;
    logic [ADDR_WIDTH-1:0] o_addr_q,   o_addr_d;
    logic                  o_idle_q,   o_idle_d;
    logic                  o_busy_q,   o_busy_d;
    logic                  o_done_q,   o_done_d;

    logic                  accept;
    logic                  flush_emit;
    logic                  border;
    logic [DATA_WIDTH-1:0] lb0_rd_dat;
    logic [DATA_WIDTH-1:0] lb1_rd_dat;
    int                    gx_i;
    int                    gy_i;
    logic signed [GW-1:0]  gx;
    logic signed [GW-1:0]  gy;
    logic [GW-1:0]         abs_gx;
    logic [GW-1:0]         abs_gy;
    logic [GW-1:0]         mag;
    logic [DATA_WIDTH-1:0] pix;

    assign accept     = (state_q == S_RUN) && i_valid;
    assign flush_emit = (state_q == S_FLUSH) && !s1_vld_q && !(o_valid_q && o_addr_q == LAST_IDX);
    assign border     = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                        (out_col_q == '0) || (out_col_q == COL_LAST);

    // lb0 holds the previous row, lb1 the row before it; lb1 is fed from lb0's old entry.
    sobel_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMAGE_WIDTH),
        .AW         (CW)
    ) u_lb0 (
        .clk    (clk),
        .we     (accept),
        .addr   (in_col_q),
        .wr_dat (i_pixel),
        .rd_dat (lb0_rd_dat)
    );

    sobel_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMAGE_WIDTH),
        .AW         (CW)
    ) u_lb1 (
        .clk    (clk),
        .we     (accept),
        .addr   (in_col_q),
        .wr_dat (lb0_rd_dat),
        .rd_dat (lb1_rd_dat)
    );

    always_comb begin
        gx_i = (K_SIDE * int'(win_q[0][2]) + K_MID * int'(win_q[1][2]) + K_SIDE * int'(win_q[2][2]))
             - (K_SIDE * int'(win_q[0][0]) + K_MID * int'(win_q[1][0]) + K_SIDE * int'(win_q[2][0]));
        gy_i = (K_SIDE * int'(win_q[2][0]) + K_MID * int'(win_q[2][1]) + K_SIDE * int'(win_q[2][2]))
             - (K_SIDE * int'(win_q[0][0]) + K_MID * int'(win_q[0][1]) + K_SIDE * int'(win_q[0][2]));
        gx     = GW'(gx_i);
        gy     = GW'(gy_i);
        abs_gx = gx[GW-1] ? -gx : gx;
        abs_gy = gy[GW-1] ? -gy : gy;
        mag    = abs_gx + abs_gy;
`ifdef SOBEL_THRESHOLD_EN
        pix = (mag >= GW'(THRESHOLD)) ? {DATA_WIDTH{1'b1}} : '0;
`else
        pix = (mag > MAG_MAX) ? {DATA_WIDTH{1'b1}} : mag[DATA_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        in_col_d   = in_col_q;
        in_idx_d   = in_idx_q;
        win_d      = win_q;
        s1_vld_d   = 1'b0;
        out_col_d  = out_col_q;
        out_row_d  = out_row_q;
        out_addr_d = out_addr_q;
        o_valid_d  = 1'b0;
        o_pixel_d  = o_pixel_q;
        o_addr_d   = o_addr_q;

        case (state_q)
            S_IDLE: begin
                if (i_en) begin
                    state_d    = S_RUN;
                    in_col_d   = '0;
                    in_idx_d   = '0;
                    out_col_d  = '0;
                    out_row_d  = '0;
                    out_addr_d = '0;
                end
            end
            S_RUN: begin
                if (i_valid && in_idx_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (o_valid_q && o_addr_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd_dat;
            win_d[1][2] = lb0_rd_dat;
            win_d[2][2] = i_pixel;
            in_col_d    = (in_col_q == COL_LAST) ? '0 : in_col_q + CW'(1);
            in_idx_d    = (in_idx_q == LAST_IDX) ? '0 : in_idx_q + ADDR_WIDTH'(1);
            // The window is centred on index in_idx_q-IMAGE_WIDTH-1 once enough rows exist.
            s1_vld_d    = (in_idx_q >= FIRST_OUT);
        end

        if (s1_vld_q || flush_emit) begin
            o_valid_d  = 1'b1;
            o_addr_d   = out_addr_q;
            o_pixel_d  = (flush_emit || border) ? '0 : pix;
            out_addr_d = out_addr_q + ADDR_WIDTH'(1);
            out_col_d  = (out_col_q == COL_LAST) ? '0 : out_col_q + CW'(1);
            if (out_col_q == COL_LAST) begin
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
            end
        end

        o_idle_d = (state_d == S_IDLE);
        o_busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        o_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_col_q   <= '0;
            in_idx_q   <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            s1_vld_q   <= 1'b0;
            out_col_q  <= '0;
            out_row_q  <= '0;
            out_addr_q <= '0;
            o_valid_q  <= 1'b0;
            o_pixel_q  <= '0;
            o_addr_q   <= '0;
            o_idle_q   <= 1'b1;
            o_busy_q   <= 1'b0;
            o_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_col_q   <= in_col_d;
            in_idx_q   <= in_idx_d;
            win_q      <= win_d;
            s1_vld_q   <= s1_vld_d;
            out_col_q  <= out_col_d;
            out_row_q  <= out_row_d;
            out_addr_q <= out_addr_d;
            o_valid_q  <= o_valid_d;
            o_pixel_q  <= o_pixel_d;
            o_addr_q   <= o_addr_d;
            o_idle_q   <= o_idle_d;
            o_busy_q   <= o_busy_d;
            o_done_q   <= o_done_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_pixel = o_pixel_q;
    assign o_addr  = o_addr_q;
    assign o_idle  = o_idle_q;
    assign o_busy  = o_busy_q;
    assign o_done  = o_done_q;

endmodule

// File: doc/sobel_filter_core.md
SOBEL_FILTER_CORE -- requirements
Module: sobel_filter_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, pixel index width.
REQ-003 Parameter IMAGE_WIDTH, default 5, pixels per row, minimum 3.
REQ-004 Parameter IMAGE_HEIGHT, default 5, rows per frame, minimum 3.
REQ-005 Parameter THRESHOLD, default 128, binarization level (used only under REQ-029).
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 i_en  input  1  one-cycle frame start pulse.
REQ-009 i_valid  input  1  i_pixel valid this cycle; raster order; no backpressure.
REQ-010 i_pixel  input  DATA_WIDTH  source pixel from the BRAM reader.
REQ-011 o_valid  output  1  o_pixel/o_addr valid this cycle.
REQ-012 o_pixel  output  DATA_WIDTH  gradient magnitude.
REQ-013 o_addr  output  ADDR_WIDTH  raster index of o_pixel, for the BRAM writer.
REQ-014 o_idle, o_busy, o_done  output  1 each  state flags; o_done is a one-cycle pulse.

Function
REQ-015 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on i_en; RUN->FLUSH after pixel N-1 (N=IMAGE_WIDTH*IMAGE_HEIGHT) accepted; FLUSH->DONE after output N-1 emitted; DONE->IDLE next cycle.
REQ-016 o_idle=1 only in IDLE, o_busy=1 in RUN and FLUSH, o_done=1 only in DONE.
REQ-017 i_en outside IDLE shall be ignored; i_valid outside RUN shall be ignored.
REQ-018 Two line buffers of IMAGE_WIDTH entries plus a 3x3 window register shall hold the neighbourhood; input column/row counters wrap at IMAGE_WIDTH and at the frame end.
REQ-019 Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p20+2p21+p22)-(p00+2p01+p02), signed DATA_WIDTH+3 bits; mag=|Gx|+|Gy|, saturated to 2^DATA_WIDTH-1.
REQ-020 Border pixels (row 0, row H-1, col 0, col W-1) shall output 0; no wrap-around neighbours may contribute.
REQ-021 Latency: in RUN, when input index k+IMAGE_WIDTH+1 is accepted in cycle t, output index k shall appear with o_valid=1 in cycle t+2.
REQ-022 Outputs shall be emitted exactly once each, in ascending o_addr order 0..N-1.
REQ-023 In FLUSH, the remaining IMAGE_WIDTH+1 outputs (all border, value 0) shall be emitted one per cycle, starting the cycle after the last RUN-generated output.
REQ-024 Gaps in i_valid shall stall the pipeline without dropping or duplicating outputs.

Reset
REQ-025 rst shall force IDLE, o_valid=0, o_pixel=0, o_addr=0, o_done=0, o_busy=0, o_idle=1, and clear counters and window.
REQ-026 rst mid-frame shall abort the frame; no further o_valid until a new i_en.
REQ-027 Line buffer contents need not be cleared by reset.

Configuration
REQ-028 Macro SOBEL_THRESHOLD_EN shall select output binarization.
REQ-029 Defined: o_pixel = all ones if mag>=THRESHOLD else 0 (borders still 0). Undefined: o_pixel = saturated mag; THRESHOLD unused.

Structure
REQ-030 Shared package sobel_pkg shall hold the DATA_WIDTH/ADDR_WIDTH defaults, the state enum and the kernel coefficient constants.
REQ-031 Sub-module sobel_line_buffer (single-port, read-before-write, depth IMAGE_WIDTH) shall be instantiated twice.

Verification (5x5 default)
REQ-032 Ramp p=5r+c, continuous i_valid -> interior outputs 48, borders 0, 25 outputs, addr 0..24, one o_done.
REQ-033 Constant 100 image -> all 25 outputs 0.
REQ-034 Single 255 at (2,2), others 0 -> outputs at addr 6,7,8,11,13,16,17,18 = 255 (saturated), addr 12 = 0.
REQ-035 Ramp with i_valid toggling every other cycle -> same values/order as REQ-032; second i_en while busy ignored.
REQ-036 rst asserted after 10 pixels -> o_idle=1 next cycle, no o_valid; a fresh ramp frame then passes REQ-032.
REQ-037 With SOBEL_THRESHOLD_EN, THRESHOLD=40, ramp -> interior 255, borders 0.
